penc64to6_rr: RTL and testbench
===============================

Name: penc64to6_rr

Overview:
- Sequential 64-to-6 encoder; the inverse of the team's 6-to-64 decoder tree.
- Takes a 64-bit request vector and emits a registered 6-bit index of one asserted request, presented with valid/ready.
- Selection is round-robin by default; fixed lowest-index-first priority is selectable.
- Sits in front of the decoder path to turn multi-source requests back into a binary select.

Parameters:
- RR, 1: 1 = round-robin; 0 = fixed priority (lowest index wins, pointer unused).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable; 0 blocks new captures.
- req  input  64  request vector, level-sensitive; bit i = source i.
- out_ready  input  1  downstream accepts idx this cycle.
- out_valid  output  1  idx holds a valid encoded request.
- idx  output  6  encoded index of the granted request.
- grant  output  64  one-hot of idx, registered with idx; all zero when out_valid=0.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, idx=0, grant=0, ptr=0. Release is effective on the first clk edge with rst_n=1.
- Load condition: load = en & (~out_valid | out_ready), evaluated each edge.
- Selection when load=1:
  - If req≠0: capture the selected index into idx, set grant=1<<idx, out_valid=1. Latency is 1 cycle from req to out_valid.
  - If req=0: out_valid=0, grant=0, idx holds its value.
- Round-robin selection (RR=1):
  - mreq = req & (all-ones << ptr).
  - If mreq≠0, select the lowest set bit of mreq; otherwise select the lowest set bit of req (wrap-around).
  - On load with a selection, ptr <= idx_next+1 mod 64, so 63 wraps to 0.
- Fixed priority (RR=0): select the lowest set bit of req; ptr stays 0.
- Stall: when out_valid=1 and out_ready=0, idx, grant and out_valid hold. req changes are ignored, including deassertion of the held request.
- en=0 and out_valid=1: out_valid holds until out_ready=1, then clears to 0 on that edge; no new capture. ptr holds while en=0.
- Simultaneous accept and new request: if out_valid&out_ready&en and req≠0, the next index loads on the same edge with no bubble. Full throughput is one index per cycle.
- Requests are levels. A source stays granted repeatedly under RR=0 until it drops req. Under RR=1, every asserted source is granted within 64 accepted grants.
- Reset mid-operation: all state clears immediately; a pending un-accepted idx is lost.

Decomposition:
- Package penc_pkg:
  - N_REQ=64, IDX_W=6, GRP=8, GRP_W=3.
  - typedef req_t (logic [63:0]), typedef idx_t (logic [5:0]).
- Sub-module pri_enc8to3:
  - Combinational. Inputs: x[7:0]. Outputs: b[2:0] = lowest set bit, v = |x.
  - Instantiated 8× on req groups and 1× on the group-valid vector, giving a two-level tree (upper 3 bits from group, lower 3 from in-group).
  - One tree for the masked vector, one for the unmasked vector.
- Top-level logic: mask generation, mux between the two trees, registers, pointer.

Test Plan:
- Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid, grant, idx drop to 0 immediately, before any clk edge; after release with req=0, out_valid stays 0.
- Single request: req=1<<37, en=1, out_ready=1 -> one cycle later idx=37, grant=1<<37, out_valid=1; this repeats every cycle while held.
- Round-robin wrap, RR=1: req bits {3,40,63} held, out_ready=1 -> idx sequence 3,40,63,3,40, with no bubbles.
- Stall: req={5,9}, out_ready=0 for 4 cycles -> idx=5 held stable even after req bit 5 drops; out_ready=1 -> next idx=9.
- Fixed priority, RR=0: req={2,60}, out_ready=1 -> idx=2 every cycle; then clear bit 2 -> idx=60 one cycle later.
- en gating: out_valid=1 idx=12, en=0, out_ready=1 -> out_valid=0 next cycle with req still {12,20}; en=1 -> idx=20 (ptr=13), then 12.

Source files
------------

// File: rtl/penc64to6_rr_pkg.sv
// Shared types and sizing for the 64-to-6 round-robin encoder.
package penc_pkg;

    localparam int N_REQ = 64;
    localparam int IDX_W = 6;
    localparam int GRP   = 8;
    localparam int GRP_W = 3;

    typedef logic [N_REQ-1:0] req_t;
    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/penc64to6_rr_if.sv
// Request/grant bundle between the request sources and the encoder.
interface penc64to6_rr_if;
    import penc_pkg::*;

    logic en;
    req_t req;
    logic out_ready;
    logic out_valid;
    idx_t idx;
    req_t grant;

    modport master (output en, req, out_ready, input out_valid, idx, grant);
    modport slave  (input en, req, out_ready, output out_valid, idx, grant);
endinterface

// File: rtl/penc64to6_rr_pri_enc8to3.sv
// 8-to-3 lowest-set-bit encoder, leaf of the two-level encoder tree.
module pri_enc8to3 (
    input  logic [7:0] x,
    output logic [2:0] b,
    output logic       v
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        b = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (x[i]) b = 3'(i);
        end
        v = |x;
    end

endmodule

// File: rtl/penc64to6_rr.sv
// 64-to-6 registered encoder with round-robin (RR=1) or fixed
// lowest-index-first (RR=0) selection, valid/ready on the output.
module penc64to6_rr
    import penc_pkg::*;
#(
    parameter bit RR = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    penc64to6_rr_if.slave  bus
);

    idx_t             ptr;
    req_t             mreq;
    logic [GRP-1:0]   gv_m;
    logic [GRP-1:0]   gv_u;
    logic [GRP_W-1:0] lo_m [GRP];
    logic [GRP_W-1:0] lo_u [GRP];
    logic [GRP_W-1:0] hi_m;
    logic [GRP_W-1:0] hi_u;
    logic             any_m;
    logic             any_u;
    idx_t             sel;
    logic             load;

    // With RR=0 the pointer never leaves 0, so the mask passes everything.
    assign mreq = bus.req & ({N_REQ{1'b1}} << ptr);

    for (genvar g = 0; g < GRP; g++) begin : g_grp
        pri_enc8to3 u_enc_m (.x(mreq[g*GRP +: GRP]),    .b(lo_m[g]), .v(gv_m[g]));
        pri_enc8to3 u_enc_u (.x(bus.req[g*GRP +: GRP]), .b(lo_u[g]), .v(gv_u[g]));
    end

    pri_enc8to3 u_top_m (.x(gv_m), .b(hi_m), .v(any_m));
    pri_enc8to3 u_top_u (.x(gv_u), .b(hi_u), .v(any_u));

    // Masked tree wins when anything at or above the pointer is requesting;
    // otherwise wrap to the lowest request overall.
    always_comb begin
        sel  = any_m ? {hi_m, lo_m[hi_m]} : {hi_u, lo_u[hi_u]};
        load = bus.en & (~bus.out_valid | bus.out_ready);
    end

    // Output registers and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.idx       <= '0;
            bus.grant     <= '0;
            ptr           <= '0;
        end else if (load) begin
            if (any_u) begin
                bus.out_valid <= 1'b1;
                bus.idx       <= sel;
                bus.grant     <= req_t'(1) << sel;
                if (RR) ptr <= idx_t'(sel + 6'd1);
            end else begin
                bus.out_valid <= 1'b0;
                bus.grant     <= '0;
            end
        end else if (bus.out_valid && bus.out_ready) begin
            // en=0: let the pending index drain, but capture nothing new.
            bus.out_valid <= 1'b0;
            bus.grant     <= '0;
        end
    end

endmodule

// File: tb/tb_penc64to6_rr.sv
// Directed bench for penc64to6_rr: one RR=1 instance and one RR=0 instance.
module tb_penc64to6_rr;
    import penc_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    penc64to6_rr_if bus_a ();
    penc64to6_rr_if bus_b ();

    penc64to6_rr #(.RR(1'b1)) u_dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    penc64to6_rr #(.RR(1'b0)) u_dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v, input int i);
        check({tag, ".valid"}, 64'(bus_a.out_valid), 64'(v));
        check({tag, ".idx"},   64'(bus_a.idx),       64'(i));
        check({tag, ".grant"}, bus_a.grant, v ? (64'd1 << i) : 64'd0);
    endtask

    task automatic chk_b(input string tag, input logic v, input int i);
        check({tag, ".valid"}, 64'(bus_b.out_valid), 64'(v));
        check({tag, ".idx"},   64'(bus_b.idx),       64'(i));
        check({tag, ".grant"}, bus_b.grant, v ? (64'd1 << i) : 64'd0);
    endtask

    initial begin
        int rr_seq [5];
        checks = 0;
        errors = 0;
        rr_seq = '{3, 40, 63, 3, 40};

        rst_n = 1'b0;
        bus_a.en = 1'b0; bus_a.req = '0; bus_a.out_ready = 1'b0;
        bus_b.en = 1'b0; bus_b.req = '0; bus_b.out_ready = 1'b0;
        #1;
        chk_a("rst_a", 1'b0, 0);
        chk_b("rst_b", 1'b0, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        chk_a("idle_a", 1'b0, 0);

        // Single held request: re-granted every cycle.
        bus_a.en = 1'b1; bus_a.out_ready = 1'b1; bus_a.req = 64'd1 << 37;
        cyc();
        chk_a("single0", 1'b1, 37);
        cyc();
        chk_a("single1", 1'b1, 37);

        // Async reset mid-stream clears outputs before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk_a("rst_mid", 1'b0, 0);
        bus_a.req = '0;
        #3 rst_n = 1'b1;
        cyc();
        chk_a("rst_rel", 1'b0, 0);

        // Round-robin wrap, pointer starts at 0.
        bus_a.req = (64'd1 << 3) | (64'd1 << 40) | (64'd1 << 63);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk_a($sformatf("rr%0d", k), 1'b1, rr_seq[k]);
        end
        // ptr is now 41; drain with no requests.
        bus_a.req = '0;
        cyc();
        chk_a("drain", 1'b0, 40);

        // Stall: idx=5 held even after its request drops.
        bus_a.req = (64'd1 << 5) | (64'd1 << 9);
        bus_a.out_ready = 1'b0;
        cyc();
        chk_a("stall_ld", 1'b1, 5);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) bus_a.req = 64'd1 << 9;
            cyc();
            chk_a($sformatf("stall%0d", k), 1'b1, 5);
        end
        bus_a.out_ready = 1'b1;
        cyc();
        chk_a("stall_rel", 1'b1, 9);

        // en gating: ptr=10, so 12 first, then drain with en=0, then 20, 12.
        bus_a.req = (64'd1 << 12) | (64'd1 << 20);
        cyc();
        chk_a("en_12", 1'b1, 12);
        bus_a.en = 1'b0;
        cyc();
        chk_a("en_off0", 1'b0, 12);
        cyc();
        chk_a("en_off1", 1'b0, 12);
        bus_a.en = 1'b1;
        cyc();
        chk_a("en_20", 1'b1, 20);
        cyc();
        chk_a("en_12b", 1'b1, 12);

        // Fixed priority instance.
        bus_b.en = 1'b1; bus_b.out_ready = 1'b1;
        bus_b.req = (64'd1 << 2) | (64'd1 << 60);
        cyc();
        chk_b("fp0", 1'b1, 2);
        cyc();
        chk_b("fp1", 1'b1, 2);
        cyc();
        chk_b("fp2", 1'b1, 2);
        bus_b.req = 64'd1 << 60;
        cyc();
        chk_b("fp60", 1'b1, 60);
        bus_b.req = (64'd1 << 2) | (64'd1 << 60);
        cyc();
        chk_b("fp_back", 1'b1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
